// File: rtl/glitc_config_ctrl.sv
// Per-GLITC configuration sequencer: one independent FSM per channel drives PROGRAM_B/INIT_B,
// watches synchronized INIT_B/DONE, and tells the GLITCBUS master when a channel is usable.
module glitc_config_ctrl #(
  parameter int unsigned NUM_GLITC    = 4,
  parameter int unsigned PROG_CYCLES  = 64,
  parameter int unsigned HOLD_CYCLES  = 16,
  parameter int unsigned INIT_TIMEOUT = 65535
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [NUM_GLITC-1:0]   prog_req_i,
  output logic [NUM_GLITC-1:0]   gready_o,
  output logic [NUM_GLITC-1:0]   PROGRAM_B,
  input  logic [NUM_GLITC-1:0]   init_b_i,
  output logic [NUM_GLITC-1:0]   init_b_oe_o,
  input  logic [NUM_GLITC-1:0]   done_i,
  output logic [3*NUM_GLITC-1:0] state_o,
  output logic [NUM_GLITC-1:0]   err_o
);

  localparam int unsigned CNT_MAX_A = (PROG_CYCLES > HOLD_CYCLES) ? PROG_CYCLES : HOLD_CYCLES;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > INIT_TIMEOUT) ? CNT_MAX_A : INIT_TIMEOUT;
  localparam int unsigned CW        = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    UNCONF  = 3'd0,
    PROG    = 3'd1,
    HOLD    = 3'd2,
    RELEASE = 3'd3,
    LOAD    = 3'd4,
    READY   = 3'd5,
    ERROR   = 3'd6
  } state_t;

  for (genvar g = 0; g < NUM_GLITC; g++) begin : g_ch
    logic [1:0]    init_sync;
    logic [1:0]    done_sync;
    logic          init_s;
    logic          done_s;
    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic          gready_q;
    logic          prog_b_q;
    logic          oe_q;
    logic          err_q;

    assign init_s = init_sync[1];
    assign done_s = done_sync[1];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        init_sync <= '0;
        done_sync <= '0;
      end else begin
        init_sync <= {init_sync[0], init_b_i[g]};
        done_sync <= {done_sync[0], done_i[g]};
      end
    end

    always_comb begin
      state_d = state_q;
      case (state_q)
        UNCONF:  if (done_s) state_d = READY;
        PROG:    if (cnt_q == CW'(PROG_CYCLES - 1)) state_d = HOLD;
        HOLD:    if (cnt_q == CW'(HOLD_CYCLES - 1)) state_d = RELEASE;
        RELEASE: begin
          if (init_s)                                 state_d = LOAD;
          else if (cnt_q == CW'(INIT_TIMEOUT - 1))    state_d = ERROR;
        end
        // A CRC error (INIT_B low) outranks a simultaneous DONE.
        LOAD: begin
          if (!init_s)     state_d = ERROR;
          else if (done_s) state_d = READY;
        end
        READY:   if (!done_s) state_d = UNCONF;
        ERROR:   state_d = ERROR;
        default: state_d = UNCONF;
      endcase
      if (prog_req_i[g]) state_d = PROG;
    end

    // Pin outputs follow the next state so they move together with state_o;
    // gready lags entry into READY by one cycle but drops on the exit edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        state_q  <= UNCONF;
        cnt_q    <= '0;
        gready_q <= 1'b0;
        prog_b_q <= 1'b1;
        oe_q     <= 1'b0;
        err_q    <= 1'b0;
      end else begin
        state_q <= state_d;
        if (prog_req_i[g] || (state_d != state_q)) begin
          cnt_q <= '0;
        end else if (cnt_q != '1) begin
          cnt_q <= cnt_q + 1'b1;
        end
        gready_q <= (state_q == READY) && (state_d == READY);
        prog_b_q <= (state_d != PROG);
        oe_q     <= (state_d == PROG) || (state_d == HOLD);
        if (prog_req_i[g]) begin
          err_q <= 1'b0;
        end else if (((state_d == ERROR) && (state_q != ERROR)) ||
                     ((state_q == READY) && (state_d == UNCONF))) begin
          err_q <= 1'b1;
        end
      end
    end

    assign gready_o[g]       = gready_q;
    assign PROGRAM_B[g]      = prog_b_q;
    assign init_b_oe_o[g]    = oe_q;
    assign err_o[g]          = err_q;
    assign state_o[3*g +: 3] = state_q;
  end

endmodule

// File: tb/tb_glitc_config_ctrl.sv
// Bench for glitc_config_ctrl: directed scenarios plus a random soak, checked every cycle
// against a timeline-based reference model through an expectation queue.
module tb_glitc_config_ctrl;
  localparam int N = 4;
  localparam int P = 64;
  localparam int H = 16;
  localparam int T = 255;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   prog_req;
  logic [N-1:0]   gready;
  logic [N-1:0]   prog_b;
  logic [N-1:0]   init_b;
  logic [N-1:0]   init_oe;
  logic [N-1:0]   done;
  logic [3*N-1:0] state;
  logic [N-1:0]   err;

  glitc_config_ctrl #(
    .NUM_GLITC   (N),
    .PROG_CYCLES (P),
    .HOLD_CYCLES (H),
    .INIT_TIMEOUT(T)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .prog_req_i (prog_req),
    .gready_o   (gready),
    .PROGRAM_B  (prog_b),
    .init_b_i   (init_b),
    .init_b_oe_o(init_oe),
    .done_i     (done),
    .state_o    (state),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3*N-1:0] st;
    logic [N-1:0]   gr;
    logic [N-1:0]   pb;
    logic [N-1:0]   oe;
    logic [N-1:0]   er;
  } obs_t;

  obs_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: mode 1 is a running configuration session whose visible
  // phase (PROG/HOLD/RELEASE) is derived from time elapsed since the request.
  int m_mode[N];
  int m_start[N];
  int m_code[N];
  bit m_err[N];
  bit i1[N], i2[N], d1[N], d2[N];
  int cyc = 0;

  function automatic int timed_code(int e);
    if (e < P)          return 1;
    else if (e < P + H) return 2;
    else                return 3;
  endfunction

  initial begin
    obs_t e;
    int   pre;
    int   post;
    bit   is;
    bit   ds;
    forever begin
      @(posedge clk);
      cyc++;
      e = '0;
      if (!rst_n) begin
        for (int ch = 0; ch < N; ch++) begin
          m_mode[ch] = 0; m_code[ch] = 0; m_err[ch] = 0;
          i1[ch] = 0; i2[ch] = 0; d1[ch] = 0; d2[ch] = 0;
        end
        e.pb = '1;
      end else begin
        for (int ch = 0; ch < N; ch++) begin
          is  = i2[ch];
          ds  = d2[ch];
          pre = m_code[ch];
          if (prog_req[ch]) begin
            m_mode[ch] = 1; m_start[ch] = cyc; m_err[ch] = 0;
          end else begin
            case (m_mode[ch])
              0: if (ds) m_mode[ch] = 5;
              1: begin
                if (pre == 3 && is) m_mode[ch] = 4;
                else if (cyc - m_start[ch] >= P + H + T) begin m_mode[ch] = 6; m_err[ch] = 1; end
              end
              4: begin
                if (!is)     begin m_mode[ch] = 6; m_err[ch] = 1; end
                else if (ds) m_mode[ch] = 5;
              end
              5: if (!ds) begin m_mode[ch] = 0; m_err[ch] = 1; end
              default: ;
            endcase
          end
          post = (m_mode[ch] == 1) ? timed_code(cyc - m_start[ch]) : m_mode[ch];
          m_code[ch]       = post;
          e.st[3*ch +: 3]  = post[2:0];
          e.gr[ch]         = (pre == 5) && (post == 5);
          e.pb[ch]         = (post != 1);
          e.oe[ch]         = (post == 1) || (post == 2);
          e.er[ch]         = m_err[ch];
          i2[ch] = i1[ch]; i1[ch] = init_b[ch];
          d2[ch] = d1[ch]; d1[ch] = done[ch];
        end
      end
      exp_q.push_back(e);
    end
  end

  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(negedge clk);
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty at t=%0t: no expectation available", $time);
      end else begin
        e = exp_q.pop_front();
        a = {state, gready, prog_b, init_oe, err};
        if (a !== e) begin
          n_fail++;
          $display("FAIL cycle_obs t=%0t: got st=%h gr=%b pb=%b oe=%b er=%b, expected st=%h gr=%b pb=%b oe=%b er=%b",
                   $time, a.st, a.gr, a.pb, a.oe, a.er, e.st, e.gr, e.pb, e.oe, e.er);
        end
      end
    end
  end

  // Pin pulse widths, recorded when each pulse ends.
  int pb_run[N], pb_last[N], oe_run[N], oe_last[N];
  initial begin
    forever begin
      @(negedge clk);
      for (int ch = 0; ch < N; ch++) begin
        if (!prog_b[ch]) pb_run[ch]++;
        else if (pb_run[ch] != 0) begin pb_last[ch] = pb_run[ch]; pb_run[ch] = 0; end
        if (init_oe[ch]) oe_run[ch]++;
        else if (oe_run[ch] != 0) begin oe_last[ch] = oe_run[ch]; oe_run[ch] = 0; end
      end
    end
  end

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [N-1:0] m);
    prog_req = m;
    tick(1);
    prog_req = '0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int r;
    rst_n    = 1'b0;
    prog_req = '0;
    init_b   = '1;
    done     = 4'b0101;
    tick(3);
    rst_n = 1'b1;
    tick(6);
    check("reset_gready", 32'(gready), 32'h5);
    check("reset_progb", 32'(prog_b), 32'hF);
    check("reset_state_ch0", 32'(state[2:0]), 32'd5);
    check("reset_state_ch1", 32'(state[5:3]), 32'd0);

    // Successful configuration of ch1.
    pulse(4'b0010);
    init_b[1] = 1'b0;
    tick(85);
    check("ch1_in_release", 32'(state[5:3]), 32'd3);
    check("ch1_progb_width", 32'(pb_last[1]), 32'd64);
    check("ch1_oe_width", 32'(oe_last[1]), 32'd80);
    check("others_untouched", 32'({state[11:6], state[2:0]}), 32'({3'd0, 3'd5, 3'd5}));
    r = $urandom_range(5, 50);
    tick(r);
    init_b[1] = 1'b1;
    tick(100);
    check("ch1_load", 32'(state[5:3]), 32'd4);
    done[1] = 1'b1;
    tick(6);
    check("ch1_ready", 32'(state[5:3]), 32'd5);
    check("ch1_gready", 32'(gready[1]), 32'd1);

    // INIT_B never releases: timeout to ERROR.
    pulse(4'b0010);
    done[1]   = 1'b0;
    init_b[1] = 1'b0;
    tick(P + H + T + 10);
    check("ch1_timeout_state", 32'(state[5:3]), 32'd6);
    check("ch1_timeout_err", 32'(err[1]), 32'd1);
    check("ch1_timeout_gready", 32'(gready[1]), 32'd0);

    // CRC error and DONE in the same cycle during LOAD.
    pulse(4'b0010);
    tick(P + H + 5 + $urandom_range(0, 20));
    init_b[1] = 1'b1;
    tick(10);
    check("ch1_load2", 32'(state[5:3]), 32'd4);
    init_b[1] = 1'b0;
    done[1]   = 1'b1;
    tick(5);
    check("ch1_crc_state", 32'(state[5:3]), 32'd6);
    check("ch1_crc_err", 32'(err[1]), 32'd1);
    done[1] = 1'b0;
    pulse(4'b0010);
    tick(2);
    check("ch1_err_cleared", 32'(err[1]), 32'd0);
    check("ch1_reprog", 32'(state[5:3]), 32'd1);

    // ch3 comes up on its own, then loses DONE; restart mid-PROG.
    done[3] = 1'b1;
    tick(6);
    check("ch3_ready", 32'(state[11:9]), 32'd5);
    done[3] = 1'b0;
    tick(5);
    check("ch3_drop_state", 32'(state[11:9]), 32'd0);
    check("ch3_drop_err", 32'(err[3]), 32'd1);
    check("ch3_drop_gready", 32'(gready[3]), 32'd0);
    pulse(4'b1000);
    tick(19);
    pulse(4'b1000);
    tick(110);
    check("ch3_restart_progb", 32'(pb_last[3]), 32'd84);
    check("ch3_restart_oe", 32'(oe_last[3]), 32'd100);

    // Simultaneous requests, then random soak.
    pulse(4'b0101);
    tick($urandom_range(10, 120));
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 199) == 0) prog_req = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 39) == 0) init_b[$urandom_range(0, N-1)] ^= 1'b1;
      if ($urandom_range(0, 59) == 0) done[$urandom_range(0, N-1)] ^= 1'b1;
      tick(1);
      prog_req = '0;
    end
    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
